// File: rtl/dds_ctrl_pkg.sv
// Shared constants, types and frequency-word helpers for the DDS control-word sequencer.
package dds_ctrl_pkg;

  localparam int IDX_W  = 3;
  localparam int FREQ_N = 8;
  localparam int FW_W   = 32;
  localparam int PW_W   = 12;

  typedef logic [0:FREQ_N-1][31:0]     freq_tab_t;
  typedef logic [0:FREQ_N-1][FW_W-1:0] fword_tab_t;

  localparam freq_tab_t FREQ_HZ = '{
    32'd100,    32'd1_000,   32'd2_000,     32'd10_000,
    32'd20_000, 32'd100_000, 32'd1_000_000, 32'd5_000_000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    RESYNC = 2'd2
  } state_t;

  function automatic logic [FW_W-1:0] fword_calc(input logic [63:0] f, input logic [63:0] clk_hz);
    return FW_W'((f << FW_W) / clk_hz);
  endfunction

  function automatic fword_tab_t fword_table(input logic [63:0] clk_hz);
    fword_tab_t tab;
    for (int i = 0; i < FREQ_N; i++) begin
      tab[i] = fword_calc({32'd0, FREQ_HZ[i]}, clk_hz);
    end
    return tab;
  endfunction

endpackage

// File: rtl/dds_word_lut.sv
// Registered index-to-word lookup for one DDS channel: frequency index to Fword,
// phase index to Pword (45 degree steps).
module dds_word_lut
  import dds_ctrl_pkg::*;
#(
  parameter int CLK_HZ = 125_000_000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] fidx,
  input  logic [IDX_W-1:0] pidx,
  output logic [FW_W-1:0]  fword,
  output logic [PW_W-1:0]  pword
);

  localparam fword_tab_t FW_TAB = fword_table(64'(CLK_HZ));

  // Word registers, reset to the 100 Hz word and zero phase.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fword <= FW_TAB[0];
      pword <= {PW_W{1'b0}};
    end else begin
      fword <= FW_TAB[fidx];
      pword <= {pidx, {(PW_W-IDX_W){1'b0}}};
    end
  end

endmodule

// File: rtl/dds_word_ctrl.sv
// Key-driven frequency/phase word sequencer for the dual-channel DDS with aligned phase restart.
// Optional automatic frequency sweep when DDS_SWEEP_EN is defined.
module dds_word_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 125_000_000,
  parameter int RST_CYCLES = 4
`ifdef DDS_SWEEP_EN
  ,
  parameter int SWEEP_DIV  = 125_000_000
`endif
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [3:0]      Key_flag,
`ifdef DDS_SWEEP_EN
  input  logic            Sweep_en,
`endif
  output logic [FW_W-1:0] Fword1,
  output logic [FW_W-1:0] Fword2,
  output logic [PW_W-1:0] Pword1,
  output logic [PW_W-1:0] Pword2,
  output logic            Phase_rst,
  output logic            Busy
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t           state_r, state_nx_s;
  logic [7:0]       cnt_r, cnt_nx_s;
  logic [IDX_W-1:0] fidx1_r, fidx2_r;
  logic [IDX_W-1:0] pidx1_r, pidx2_r, pidx1_nx_s, pidx2_nx_s;
  logic             pend1_r, pend2_r, pend1_nx_s, pend2_nx_s;
  logic             req1_s, req2_s;
  logic             sweep_tick_s;

`ifdef DDS_SWEEP_EN
  localparam logic [31:0] DIV_LAST = 32'(SWEEP_DIV - 1);
  logic [31:0] div_r;

  // Sweep divider: free-runs while enabled, held at zero otherwise.
  always_ff @(posedge Clk) begin
    if (Reset || !Sweep_en || (div_r == DIV_LAST)) begin
      div_r <= 32'd0;
    end else begin
      div_r <= div_r + 32'd1;
    end
  end

  assign sweep_tick_s = Sweep_en && (div_r == DIV_LAST);
`else
  assign sweep_tick_s = 1'b0;
`endif

  // Frequency indices; a sweep tick coinciding with a key gives a single step.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fidx1_r <= {IDX_W{1'b0}};
      fidx2_r <= {IDX_W{1'b0}};
    end else begin
      if (Key_flag[0] || sweep_tick_s) fidx1_r <= fidx1_r + 3'd1;
      if (Key_flag[2] || sweep_tick_s) fidx2_r <= fidx2_r + 3'd1;
    end
  end

  assign req1_s = Key_flag[1] | pend1_r;
  assign req2_s = Key_flag[3] | pend2_r;

  // Phase FSM next-state, phase index and pending-flag logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pidx1_nx_s = pidx1_r;
    pidx2_nx_s = pidx2_r;
    pend1_nx_s = pend1_r;
    pend2_nx_s = pend2_r;
    case (state_r)
      IDLE: begin
        pend1_nx_s = 1'b0;
        pend2_nx_s = 1'b0;
        cnt_nx_s   = 8'd0;
        if (req1_s) pidx1_nx_s = pidx1_r + 3'd1;
        else        pidx1_nx_s = pidx1_r;
        if (req2_s) pidx2_nx_s = pidx2_r + 3'd1;
        else        pidx2_nx_s = pidx2_r;
        if (req1_s || req2_s) state_nx_s = ARM;
        else                  state_nx_s = IDLE;
      end
      ARM: begin
        pend1_nx_s = pend1_r | Key_flag[1];
        pend2_nx_s = pend2_r | Key_flag[3];
        cnt_nx_s   = 8'd0;
        state_nx_s = RESYNC;
      end
      RESYNC: begin
        pend1_nx_s = pend1_r | Key_flag[1];
        pend2_nx_s = pend2_r | Key_flag[3];
        if (cnt_r == RST_LAST) begin
          cnt_nx_s   = 8'd0;
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s   = cnt_r + 8'd1;
          state_nx_s = RESYNC;
        end
      end
      default: begin
        cnt_nx_s   = 8'd0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Phase FSM registers; Phase_rst and Busy are registered decodes of the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      cnt_r     <= 8'd0;
      pidx1_r   <= {IDX_W{1'b0}};
      pidx2_r   <= {IDX_W{1'b0}};
      pend1_r   <= 1'b0;
      pend2_r   <= 1'b0;
      Phase_rst <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      pidx1_r   <= pidx1_nx_s;
      pidx2_r   <= pidx2_nx_s;
      pend1_r   <= pend1_nx_s;
      pend2_r   <= pend2_nx_s;
      Phase_rst <= (state_nx_s == RESYNC);
      Busy      <= (state_nx_s != IDLE);
    end
  end

  dds_word_lut #(.CLK_HZ(CLK_HZ)) u_lut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .fidx  (fidx1_r),
    .pidx  (pidx1_r),
    .fword (Fword1),
    .pword (Pword1)
  );

  dds_word_lut #(.CLK_HZ(CLK_HZ)) u_lut2 (
    .Clk   (Clk),
    .Reset (Reset),
    .fidx  (fidx2_r),
    .pidx  (pidx2_r),
    .fword (Fword2),
    .pword (Pword2)
  );

endmodule

// File: tb/tb_dds_word_ctrl.sv
// Self-checking bench for dds_word_ctrl: directed scenarios plus a randomized run
// against a timestamp-based reference model. Sweep scenario only with DDS_SWEEP_EN.
module tb_dds_word_ctrl;

  localparam int CLK_HZ     = 125_000_000;
  localparam int RST_CYCLES = 4;
`ifdef DDS_SWEEP_EN
  localparam int SWEEP_DIV  = 10;
  logic Sweep_en = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Key_flag = 4'b0000;
  logic [31:0] Fword1, Fword2;
  logic [11:0] Pword1, Pword2;
  logic        Phase_rst, Busy;

  int checks = 0;
  int errors = 0;

  longint unsigned freq_tab [8] = '{100, 1000, 2000, 10000, 20000, 100000, 1000000, 5000000};

  always #4 Clk = ~Clk;

  dds_word_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .RST_CYCLES (RST_CYCLES)
`ifdef DDS_SWEEP_EN
    ,
    .SWEEP_DIV  (SWEEP_DIV)
`endif
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Key_flag  (Key_flag),
`ifdef DDS_SWEEP_EN
    .Sweep_en  (Sweep_en),
`endif
    .Fword1    (Fword1),
    .Fword2    (Fword2),
    .Pword1    (Pword1),
    .Pword2    (Pword2),
    .Phase_rst (Phase_rst),
    .Busy      (Busy)
  );

  function automatic logic [31:0] exp_fword(input int idx);
    longint unsigned p;
    p = (freq_tab[idx] * 64'd4294967296) / 64'(CLK_HZ);
    return p[31:0];
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Key_flag = 4'b0000;
`ifdef DDS_SWEEP_EN
    Sweep_en = 1'b0;
`endif
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) step();
    checks++; if (Fword1 !== 32'd3435) begin errors++; $display("FAIL reset_fw1: got %0d want 3435", Fword1); end
    checks++; if (Fword2 !== 32'd3435) begin errors++; $display("FAIL reset_fw2: got %0d want 3435", Fword2); end
    checks++; if (Pword1 !== 12'd0) begin errors++; $display("FAIL reset_pw1: got %0d want 0", Pword1); end
    checks++; if (Pword2 !== 12'd0) begin errors++; $display("FAIL reset_pw2: got %0d want 0", Pword2); end
    checks++; if (Phase_rst !== 1'b0) begin errors++; $display("FAIL reset_prst: got %b want 0", Phase_rst); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
  endtask

  task automatic test_freq_walk();
    do_reset();
    for (int p = 1; p <= 8; p++) begin
      Key_flag = 4'b0001;
      step();
      Key_flag = 4'b0000;
      checks++; if (Fword1 !== exp_fword((p - 1) % 8)) begin errors++; $display("FAIL fw_hold p=%0d: got %0d want %0d", p, Fword1, exp_fword((p - 1) % 8)); end
      step();
      checks++; if (Fword1 !== exp_fword(p % 8)) begin errors++; $display("FAIL fw_step p=%0d: got %0d want %0d", p, Fword1, exp_fword(p % 8)); end
      checks++; if (Phase_rst !== 1'b0) begin errors++; $display("FAIL fw_prst p=%0d: got %b want 0", p, Phase_rst); end
      if (p == 7) begin
        checks++; if (Fword1 !== 32'd171798691) begin errors++; $display("FAIL fw_5mhz: got %0d want 171798691", Fword1); end
      end
      if (p == 8) begin
        checks++; if (Fword1 !== 32'd3435) begin errors++; $display("FAIL fw_wrap: got %0d want 3435", Fword1); end
      end
      repeat ($urandom_range(0, 3)) step();
    end
    checks++; if (Fword2 !== 32'd3435) begin errors++; $display("FAIL fw_other_ch: got %0d want 3435", Fword2); end
  endtask

  task automatic test_phase_single();
    int busy_cnt = 0;
    int prst_cnt = 0;
    int first = -1;
    do_reset();
    Key_flag = 4'b0010;
    step();
    Key_flag = 4'b0000;
    for (int k = 1; k <= 15; k++) begin
      if (Busy) busy_cnt++;
      if (Phase_rst) begin
        prst_cnt++;
        if (first < 0) first = k;
      end
      if (k == 1) begin
        checks++; if (Pword1 !== 12'd0) begin errors++; $display("FAIL ph_hold: got %0d want 0", Pword1); end
      end
      if (k == 2) begin
        checks++; if (Pword1 !== 12'd512) begin errors++; $display("FAIL ph_word: got %0d want 512", Pword1); end
      end
      step();
    end
    checks++; if (prst_cnt != RST_CYCLES) begin errors++; $display("FAIL ph_prst_len: got %0d want %0d", prst_cnt, RST_CYCLES); end
    checks++; if (busy_cnt != RST_CYCLES + 1) begin errors++; $display("FAIL ph_busy_len: got %0d want %0d", busy_cnt, RST_CYCLES + 1); end
    checks++; if (first != 2) begin errors++; $display("FAIL ph_prst_start: got %0d want 2", first); end
  endtask

  task automatic test_back_to_back();
    int edges = 0;
    int prst_cnt = 0;
    logic prev = 1'b0;
    do_reset();
    Key_flag = 4'b1010;
    step();
    for (int k = 1; k <= 30; k++) begin
      Key_flag = (k == 2 || k == 4) ? 4'b1000 : 4'b0000;
      if (Phase_rst && !prev) edges++;
      if (Phase_rst) prst_cnt++;
      prev = Phase_rst;
      if (k == 2) begin
        checks++; if (Pword1 !== 12'd512 || Pword2 !== 12'd512) begin errors++; $display("FAIL b2b_both: got %0d/%0d want 512/512", Pword1, Pword2); end
      end
      step();
    end
    Key_flag = 4'b0000;
    checks++; if (edges != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", edges); end
    checks++; if (prst_cnt != 2 * RST_CYCLES) begin errors++; $display("FAIL b2b_prst_cycles: got %0d want %0d", prst_cnt, 2 * RST_CYCLES); end
    checks++; if (Pword2 !== 12'd1024) begin errors++; $display("FAIL b2b_pw2: got %0d want 1024", Pword2); end
    checks++; if (Pword1 !== 12'd512) begin errors++; $display("FAIL b2b_pw1: got %0d want 512", Pword1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    Key_flag = 4'b0101;
    step();
    Key_flag = 4'b0010;
    step();
    Key_flag = 4'b0000;
    step();
    step();
    checks++; if (Phase_rst !== 1'b1) begin errors++; $display("FAIL mid_in_resync: got %b want 1", Phase_rst); end
    checks++; if (Fword1 !== 32'd34359) begin errors++; $display("FAIL mid_fw1_pre: got %0d want 34359", Fword1); end
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    checks++; if (Phase_rst !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mid_ctrl: got prst=%b busy=%b want 0/0", Phase_rst, Busy); end
    checks++; if (Fword1 !== 32'd3435 || Fword2 !== 32'd3435) begin errors++; $display("FAIL mid_fw: got %0d/%0d want 3435/3435", Fword1, Fword2); end
    checks++; if (Pword1 !== 12'd0 || Pword2 !== 12'd0) begin errors++; $display("FAIL mid_pw: got %0d/%0d want 0/0", Pword1, Pword2); end
  endtask

  // Model keeps indices, pending presses and the busy window as cycle timestamps.
  task automatic test_random();
    int f1 = 0, f2 = 0, p1 = 0, p2 = 0;
    int bs = -100, be = -100;
    bit pd1 = 1'b0, pd2 = 1'b0, r1, r2, busy_now;
    logic [31:0] ef1, ef2;
    logic [11:0] ep1, ep2;
    logic [3:0] kf;
    do_reset();
    ef1 = exp_fword(0); ef2 = exp_fword(0); ep1 = 12'd0; ep2 = 12'd0;
    for (int c = 0; c < 600; c++) begin
      busy_now = (c >= bs) && (c <= be);
      checks++; if (Fword1 !== ef1) begin errors++; $display("FAIL rnd_fw1 c=%0d: got %0d want %0d", c, Fword1, ef1); end
      checks++; if (Fword2 !== ef2) begin errors++; $display("FAIL rnd_fw2 c=%0d: got %0d want %0d", c, Fword2, ef2); end
      checks++; if (Pword1 !== ep1) begin errors++; $display("FAIL rnd_pw1 c=%0d: got %0d want %0d", c, Pword1, ep1); end
      checks++; if (Pword2 !== ep2) begin errors++; $display("FAIL rnd_pw2 c=%0d: got %0d want %0d", c, Pword2, ep2); end
      checks++; if (Busy !== busy_now) begin errors++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, Busy, busy_now); end
      checks++; if (Phase_rst !== ((c >= bs + 1) && (c <= be))) begin errors++; $display("FAIL rnd_prst c=%0d: got %b want %b", c, Phase_rst, (c >= bs + 1) && (c <= be)); end
      for (int b = 0; b < 4; b++) kf[b] = ($urandom_range(0, 5) == 0);
      Key_flag = kf;
      ef1 = exp_fword(f1); ef2 = exp_fword(f2);
      ep1 = 12'(p1 * 512); ep2 = 12'(p2 * 512);
      f1 = (f1 + int'(kf[0])) % 8;
      f2 = (f2 + int'(kf[2])) % 8;
      if (!busy_now) begin
        r1 = kf[1] | pd1;
        r2 = kf[3] | pd2;
        pd1 = 1'b0;
        pd2 = 1'b0;
        if (r1 || r2) begin
          p1 = (p1 + int'(r1)) % 8;
          p2 = (p2 + int'(r2)) % 8;
          bs = c + 1;
          be = c + 1 + RST_CYCLES;
        end
      end else begin
        pd1 = pd1 | kf[1];
        pd2 = pd2 | kf[3];
      end
      step();
    end
    Key_flag = 4'b0000;
  endtask

`ifdef DDS_SWEEP_EN
  task automatic test_sweep();
    int f1 = 0, f2 = 0;
    bit tick, k0;
    logic [31:0] ef1, ef2;
    do_reset();
    ef1 = exp_fword(0); ef2 = exp_fword(0);
    Sweep_en = 1'b1;
    for (int c = 0; c < 45; c++) begin
      checks++; if (Fword1 !== ef1) begin errors++; $display("FAIL sw_fw1 c=%0d: got %0d want %0d", c, Fword1, ef1); end
      checks++; if (Fword2 !== ef2) begin errors++; $display("FAIL sw_fw2 c=%0d: got %0d want %0d", c, Fword2, ef2); end
      tick = ((c % SWEEP_DIV) == SWEEP_DIV - 1);
      k0 = (c == 2 * SWEEP_DIV - 1);
      Key_flag = {3'b000, k0};
      ef1 = exp_fword(f1); ef2 = exp_fword(f2);
      f1 = (f1 + int'(tick | k0)) % 8;
      f2 = (f2 + int'(tick)) % 8;
      step();
    end
    Key_flag = 4'b0000;
    Sweep_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_freq_walk();
    test_phase_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DDS_SWEEP_EN
    test_sweep();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
